register_scoreboard: RTL and testbench

REGISTER_SCOREBOARD -- requirements
Module: register_scoreboard

---
 rtl/register_scoreboard_pkg.sv | 17 +
 rtl/register_scoreboard_counter.sv | 40 ++++
 rtl/register_scoreboard.sv | 103 ++++++++++
 tb/tb_register_scoreboard.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/register_scoreboard_pkg.sv
// Shared type definitions for the register scoreboard: basic datapath types
// and the pipeline-tracking types used by the pending-write counters.
package BasicTypes;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int DATA_WIDTH     = 32;

  typedef logic [REG_ADDR_WIDTH-1:0] RegAddr;
  typedef logic [DATA_WIDTH-1:0]     BasicData;
endpackage

package PipelineTypes;
  localparam int CNT_WIDTH_DEFAULT = 2;
  localparam int INFLIGHT_WIDTH    = 4;
  localparam logic [INFLIGHT_WIDTH-1:0] INFLIGHT_MAX = 4'd15;

  typedef logic [CNT_WIDTH_DEFAULT-1:0] ScoreboardCount;
endpackage

// File: rtl/register_scoreboard_counter.sv
// Per-register pending-write counter. The caller guarantees no increment at
// the maximum and no decrement at zero; clear_i wins over both.
module pending_write_counter
  import PipelineTypes::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 inc_i,
  input  logic                 dec_i,
  output logic [CNT_WIDTH-1:0] count_o
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && !dec_i) begin
      count_d = count_q + CNT_WIDTH'(1);
    end else if (dec_i && !inc_i) begin
      count_d = count_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/register_scoreboard.sv
// Register scoreboard: tracks pending writes per architectural register and
// decides whether the instruction in decode may issue or must stall.
module register_scoreboard
  import BasicTypes::*;
  import PipelineTypes::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issueValid,
  input  logic                      issueWEnable,
  input  RegAddr                    issueRdAddr,
  input  RegAddr                    rs1Addr,
  input  RegAddr                    rs2Addr,
  input  logic                      rs1Used,
  input  logic                      rs2Used,
  input  logic                      wbWEnable,
  input  RegAddr                    wbRdAddr,
  input  logic                      flush,
  output logic                      rs1Ready,
  output logic                      rs2Ready,
  output logic                      stall,
  output logic                      issueAccept,
  output logic [INFLIGHT_WIDTH-1:0] inflightCount,
  output logic                      pipelineEmpty,
  output logic                      sbError
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt [NUM_REGS];
  logic rd_full;
  logic wb_pending;
  logic do_inc;
  logic do_dec;
  logic wb_orphan;

  logic [INFLIGHT_WIDTH-1:0] inflight_q;
  logic [INFLIGHT_WIDTH-1:0] inflight_d;
  logic                      sb_error_q;
  logic                      sb_error_d;

  assign cnt[0] = '0;

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
      pending_write_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear_i(flush),
        .inc_i  (do_inc && (issueRdAddr == RegAddr'(gi))),
        .dec_i  (do_dec && (wbRdAddr == RegAddr'(gi))),
        .count_o(cnt[gi])
      );
    end
  endgenerate

  // A single outstanding write that retires this cycle is forwarded by the
  // register file, so the source counts as ready.
  assign rs1Ready = !rs1Used || (rs1Addr == '0) || (cnt[rs1Addr] == '0) ||
                    ((cnt[rs1Addr] == CNT_ONE) && wbWEnable && (wbRdAddr == rs1Addr));
  assign rs2Ready = !rs2Used || (rs2Addr == '0) || (cnt[rs2Addr] == '0) ||
                    ((cnt[rs2Addr] == CNT_ONE) && wbWEnable && (wbRdAddr == rs2Addr));

  assign rd_full     = issueWEnable && (issueRdAddr != '0) && (cnt[issueRdAddr] == CNT_MAX);
  assign stall       = issueValid && !flush && (!rs1Ready || !rs2Ready || rd_full);
  assign issueAccept = issueValid && !stall && !flush;

  assign wb_pending = (cnt[wbRdAddr] != '0);
  assign do_inc     = issueAccept && issueWEnable && (issueRdAddr != '0);
  assign do_dec     = wbWEnable && (wbRdAddr != '0) && wb_pending;
  assign wb_orphan  = wbWEnable && (wbRdAddr != '0) && !wb_pending && !flush;

  always_comb begin
    inflight_d = inflight_q;
    sb_error_d = sb_error_q || wb_orphan;
    if (flush) begin
      inflight_d = '0;
    end else if (do_inc && !do_dec) begin
      if (inflight_q != INFLIGHT_MAX) inflight_d = inflight_q + INFLIGHT_WIDTH'(1);
    end else if (do_dec && !do_inc) begin
      if (inflight_q != '0) inflight_d = inflight_q - INFLIGHT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      sb_error_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      sb_error_q <= sb_error_d;
    end
  end

  assign inflightCount = inflight_q;
  assign pipelineEmpty = (inflight_q == '0);
  assign sbError       = sb_error_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed self-checking bench for register_scoreboard: one task per scenario,
// hand-computed expectations, inputs driven 1 time unit after the rising edge.
module tb_register_scoreboard;
  import BasicTypes::*;

  logic       clk;
  logic       rst;
  logic       issueValid;
  logic       issueWEnable;
  RegAddr     issueRdAddr;
  RegAddr     rs1Addr;
  RegAddr     rs2Addr;
  logic       rs1Used;
  logic       rs2Used;
  logic       wbWEnable;
  RegAddr     wbRdAddr;
  logic       flush;
  logic       rs1Ready;
  logic       rs2Ready;
  logic       stall;
  logic       issueAccept;
  logic [3:0] inflightCount;
  logic       pipelineEmpty;
  logic       sbError;

  int passed = 0;
  int total  = 0;

  register_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .issueValid   (issueValid),
    .issueWEnable (issueWEnable),
    .issueRdAddr  (issueRdAddr),
    .rs1Addr      (rs1Addr),
    .rs2Addr      (rs2Addr),
    .rs1Used      (rs1Used),
    .rs2Used      (rs2Used),
    .wbWEnable    (wbWEnable),
    .wbRdAddr     (wbRdAddr),
    .flush        (flush),
    .rs1Ready     (rs1Ready),
    .rs2Ready     (rs2Ready),
    .stall        (stall),
    .issueAccept  (issueAccept),
    .inflightCount(inflightCount),
    .pipelineEmpty(pipelineEmpty),
    .sbError      (sbError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    rst = 1'b0; issueValid = 1'b0; issueWEnable = 1'b0; issueRdAddr = '0;
    rs1Addr = '0; rs2Addr = '0; rs1Used = 1'b0; rs2Used = 1'b0;
    wbWEnable = 1'b0; wbRdAddr = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_write(input RegAddr rd);
    issueValid = 1'b1; issueWEnable = 1'b1; issueRdAddr = rd;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    idle();
    #1;
    total++; if (pipelineEmpty !== 1'b1) $display("FAIL reset_empty: got %b want 1", pipelineEmpty); else passed++;
    total++; if (inflightCount !== 4'd0) $display("FAIL reset_inflight: got %0d want 0", inflightCount); else passed++;
    total++; if (sbError !== 1'b0) $display("FAIL reset_sberror: got %b want 0", sbError); else passed++;
    issueValid = 1'b1; rs1Used = 1'b1; rs1Addr = 5'd5; rs2Used = 1'b1; rs2Addr = 5'd6;
    #1;
    total++; if (rs1Ready !== 1'b1 || rs2Ready !== 1'b1) $display("FAIL reset_ready: got %b%b want 11", rs1Ready, rs2Ready); else passed++;
    total++; if (stall !== 1'b0 || issueAccept !== 1'b1) $display("FAIL reset_issue: got stall=%b accept=%b want 0 1", stall, issueAccept); else passed++;
    $display("reset: inflight=%0d empty=%b sbError=%b", inflightCount, pipelineEmpty, sbError);
  endtask

  task automatic test_raw_hazard();
    idle(); issue_write(5'd5);
    #1;
    total++; if (issueAccept !== 1'b1) $display("FAIL raw_issue_x5: got %b want 1", issueAccept); else passed++;
    tick();
    idle(); issueValid = 1'b1; rs1Used = 1'b1; rs1Addr = 5'd5;
    #1;
    total++; if (rs1Ready !== 1'b0) $display("FAIL raw_rs1_blocked: got %b want 0", rs1Ready); else passed++;
    total++; if (stall !== 1'b1 || issueAccept !== 1'b0) $display("FAIL raw_stall: got stall=%b accept=%b want 1 0", stall, issueAccept); else passed++;
    total++; if (inflightCount !== 4'd1) $display("FAIL raw_inflight: got %0d want 1", inflightCount); else passed++;
    rs2Used = 1'b1; rs2Addr = 5'd5; wbWEnable = 1'b1; wbRdAddr = 5'd5;
    #1;
    total++; if (rs1Ready !== 1'b1 || rs2Ready !== 1'b1) $display("FAIL raw_writethrough: got %b%b want 11", rs1Ready, rs2Ready); else passed++;
    total++; if (stall !== 1'b0 || issueAccept !== 1'b1) $display("FAIL raw_writethrough_issue: got stall=%b accept=%b want 0 1", stall, issueAccept); else passed++;
    tick();
    idle(); rs2Used = 1'b1; rs2Addr = 5'd5;
    #1;
    total++; if (pipelineEmpty !== 1'b1 || rs2Ready !== 1'b1) $display("FAIL raw_drained: got empty=%b rs2Ready=%b want 1 1", pipelineEmpty, rs2Ready); else passed++;
    $display("raw hazard x5: inflight=%0d", inflightCount);
  endtask

  task automatic test_counter_full();
    idle();
    for (int i = 0; i < 3; i++) begin
      issue_write(5'd7);
      tick();
    end
    #1;
    total++; if (inflightCount !== 4'd3) $display("FAIL full_inflight3: got %0d want 3", inflightCount); else passed++;
    wbWEnable = 1'b1; wbRdAddr = 5'd7;
    #1;
    total++; if (stall !== 1'b1 || issueAccept !== 1'b0) $display("FAIL full_stall: got stall=%b accept=%b want 1 0", stall, issueAccept); else passed++;
    tick();
    wbWEnable = 1'b0;
    #1;
    total++; if (stall !== 1'b0 || issueAccept !== 1'b1) $display("FAIL full_release: got stall=%b accept=%b want 0 1", stall, issueAccept); else passed++;
    total++; if (inflightCount !== 4'd2) $display("FAIL full_inflight2: got %0d want 2", inflightCount); else passed++;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      wbWEnable = 1'b1; wbRdAddr = 5'd7;
      tick();
    end
    idle();
    #1;
    total++; if (pipelineEmpty !== 1'b1 || sbError !== 1'b0) $display("FAIL full_drain: got empty=%b sbError=%b want 1 0", pipelineEmpty, sbError); else passed++;
    $display("counter full x7: inflight=%0d", inflightCount);
  endtask

  task automatic test_same_cycle();
    idle(); issue_write(5'd9);
    tick();
    wbWEnable = 1'b1; wbRdAddr = 5'd9;
    #1;
    total++; if (issueAccept !== 1'b1) $display("FAIL same_accept: got %b want 1", issueAccept); else passed++;
    tick();
    idle(); issueValid = 1'b1; rs1Used = 1'b1; rs1Addr = 5'd9;
    #1;
    total++; if (inflightCount !== 4'd1) $display("FAIL same_inflight: got %0d want 1", inflightCount); else passed++;
    total++; if (rs1Ready !== 1'b0) $display("FAIL same_still_pending: got %b want 0", rs1Ready); else passed++;
    idle(); wbWEnable = 1'b1; wbRdAddr = 5'd9;
    tick();
    idle();
    #1;
    total++; if (pipelineEmpty !== 1'b1) $display("FAIL same_drain: got %b want 1", pipelineEmpty); else passed++;
    $display("same-cycle issue/wb x9: inflight=%0d", inflightCount);
  endtask

  task automatic test_reg_zero();
    idle(); issue_write(5'd0);
    tick();
    idle(); wbWEnable = 1'b1; wbRdAddr = 5'd0;
    tick();
    idle(); issueValid = 1'b1; rs1Used = 1'b1; rs1Addr = 5'd0;
    #1;
    total++; if (inflightCount !== 4'd0 || sbError !== 1'b0) $display("FAIL zero_state: got inflight=%0d sbError=%b want 0 0", inflightCount, sbError); else passed++;
    total++; if (rs1Ready !== 1'b1 || issueAccept !== 1'b1) $display("FAIL zero_ready: got rs1Ready=%b accept=%b want 1 1", rs1Ready, issueAccept); else passed++;
    $display("register x0: inflight=%0d", inflightCount);
  endtask

  task automatic test_flush();
    idle(); issue_write(5'd3);
    tick();
    issue_write(5'd4);
    tick();
    #1;
    total++; if (inflightCount !== 4'd2) $display("FAIL flush_pre_inflight: got %0d want 2", inflightCount); else passed++;
    issue_write(5'd8); flush = 1'b1;
    #1;
    total++; if (issueAccept !== 1'b0 || stall !== 1'b0) $display("FAIL flush_kill: got accept=%b stall=%b want 0 0", issueAccept, stall); else passed++;
    tick();
    idle(); rs1Used = 1'b1; rs1Addr = 5'd3; rs2Used = 1'b1; rs2Addr = 5'd4;
    #1;
    total++; if (rs1Ready !== 1'b1 || rs2Ready !== 1'b1) $display("FAIL flush_ready: got %b%b want 11", rs1Ready, rs2Ready); else passed++;
    total++; if (inflightCount !== 4'd0 || pipelineEmpty !== 1'b1) $display("FAIL flush_inflight: got %0d empty=%b want 0 1", inflightCount, pipelineEmpty); else passed++;
    rs1Addr = 5'd8;
    #1;
    total++; if (rs1Ready !== 1'b1) $display("FAIL flush_no_issue_x8: got %b want 1", rs1Ready); else passed++;
    $display("flush: inflight=%0d", inflightCount);
  endtask

  task automatic test_inflight_saturation();
    idle();
    for (int r = 1; r <= 16; r++) begin
      issue_write(RegAddr'(r));
      tick();
    end
    idle();
    #1;
    total++; if (inflightCount !== 4'd15) $display("FAIL sat_inflight: got %0d want 15", inflightCount); else passed++;
    flush = 1'b1;
    tick();
    idle();
    #1;
    total++; if (inflightCount !== 4'd0) $display("FAIL sat_flush: got %0d want 0", inflightCount); else passed++;
    $display("inflight saturation: inflight=%0d", inflightCount);
  endtask

  task automatic test_sb_error();
    idle(); wbWEnable = 1'b1; wbRdAddr = 5'd12;
    tick();
    idle();
    #1;
    total++; if (sbError !== 1'b1) $display("FAIL sberr_set: got %b want 1", sbError); else passed++;
    total++; if (inflightCount !== 4'd0) $display("FAIL sberr_inflight: got %0d want 0", inflightCount); else passed++;
    flush = 1'b1;
    tick();
    idle();
    #1;
    total++; if (sbError !== 1'b1) $display("FAIL sberr_after_flush: got %b want 1", sbError); else passed++;
    rst = 1'b1;
    tick();
    idle();
    #1;
    total++; if (sbError !== 1'b0) $display("FAIL sberr_after_reset: got %b want 0", sbError); else passed++;
    $display("sb error x12: sbError=%b", sbError);
  endtask

  task automatic test_reset_mid();
    idle(); issue_write(5'd10);
    tick();
    rst = 1'b1; flush = 1'b1; issueRdAddr = 5'd11; wbWEnable = 1'b1; wbRdAddr = 5'd10;
    tick();
    idle(); rs1Used = 1'b1; rs1Addr = 5'd10; rs2Used = 1'b1; rs2Addr = 5'd11;
    #1;
    total++; if (inflightCount !== 4'd0 || sbError !== 1'b0) $display("FAIL midrst_state: got inflight=%0d sbError=%b want 0 0", inflightCount, sbError); else passed++;
    total++; if (rs1Ready !== 1'b1 || rs2Ready !== 1'b1) $display("FAIL midrst_ready: got %b%b want 11", rs1Ready, rs2Ready); else passed++;
    $display("reset mid-operation: inflight=%0d", inflightCount);
  endtask

  initial begin
    idle();
    test_reset();
    test_raw_hazard();
    test_counter_full();
    test_same_cycle();
    test_reg_zero();
    test_flush();
    test_inflight_saturation();
    test_sb_error();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
